range_stats_unit: RTL and testbench
===================================

# range_stats_unit

Parametrised streaming range/statistics unit; successor to the single-width range finder. Tracks the minimum, maximum, range and sample count of a qualified data stream over a go…finish session. Supports signed or unsigned samples, a per-cycle `valid` qualifier, coded error reporting and a one-cycle `done` pulse. Sits between a sample source and a result consumer on the project's single clock domain.

## Interface
- `WIDTH`, 8: sample width in bits (≥2).
- `CNT_WIDTH`, 16: sample counter width (≥2).
- `SIGNED`, 0: 1 treats samples as two's complement; 0 treats them as unsigned.

- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  WIDTH  sample.
- `valid`  in  1  sample qualifier during a session.
- `go`  in  1  session start; always samples `data_in`.
- `finish`  in  1  session end.
- `range`  out  WIDTH  max − min, always unsigned.
- `min_out`  out  WIDTH  session minimum, in `SIGNED` interpretation.
- `max_out`  out  WIDTH  session maximum, in `SIGNED` interpretation.
- `count`  out  CNT_WIDTH  samples accepted in the last completed session.
- `done`  out  1  one-cycle pulse when results update.
- `busy`  out  1  high in RUN.
- `error`  out  1  high in ERROR.
- `err_code`  out  2  00 none, 01 finish without a session, 10 go during a session.

## Operation
- States: IDLE, RUN, DONE, ERROR. Reset enters IDLE.
- Start. Applies in IDLE or ERROR when `go`=1 and `finish`=0:
  - load running min and max from `data_in`; running count = 1;
  - `err_code` ← 00;
  - go to RUN.
- IDLE, `finish`=1 with or without `go`: go to ERROR, `err_code` ← 01.
- IDLE, all other inputs: stay in IDLE.
- RUN, priority order:
  - `go`=1: go to ERROR, `err_code` ← 10. Running values are discarded and the outputs are not updated.
  - `finish`=1: if `valid`=1, include the sample. Then latch `min_out`, `max_out`, `range`, `count` and go to DONE.
  - `valid`=1: update running min/max and increment count.
  - otherwise hold.
- DONE: lasts one cycle with `done`=1, then goes to IDLE. `go` and `finish` are ignored in this cycle.
- ERROR: `error`=1; `err_code` holds. Only a Start leaves this state. `go` and `finish` together keep the block in ERROR.
- Comparisons use signed compare when `SIGNED`=1, otherwise unsigned.
- `range` = max − min computed modulo 2^WIDTH and read as unsigned. Because max ≥ min in the chosen interpretation, the result is always exact in WIDTH bits.
- Count saturates at 2^CNT_WIDTH−1 and never wraps.
- The result outputs (`range`, `min_out`, `max_out`, `count`) hold their last completed-session values. They change only on a finish in RUN, or on reset.

## Timing
- Every output is registered. Reset value of every output is 0: `range`, `min_out`, `max_out`, `count`, `done`, `busy`, `error`, `err_code`.
- Start on edge N: `busy`=1 from N+1.
- Finish sampled at edge N: results are visible and `done`=1 in cycle N+1. `done` falls at N+2, and `busy` is 0 from N+1.
- Minimum session: go at edge N, finish at edge N+1.
- Error entry at edge N: `error`=1 and `err_code` valid from N+1.
- Reset asserted mid-session: at the next edge the block is in IDLE and all outputs are 0. Running values are lost.
- `valid` is ignored outside RUN, except that the go cycle always counts as a sample.

## Test plan
- Unsigned, WIDTH=8: go with 50; `valid` with 20, 90, 70; finish+`valid` with 10 -> `min_out`=10, `max_out`=90, `range`=80, `count`=5; `done` high for exactly one cycle, the cycle after finish.
- SIGNED=1: go with 0xFB (−5); valid 100; valid 0x80 (−128); finish with `valid`=0 and data 127 -> `min_out`=0x80, `max_out`=100, `range`=228, `count`=3.
- Valid gaps: go 40; `valid`=0 for 3 cycles carrying 0 and 255; valid 60; finish with `valid`=0 -> `range`=20, `count`=2.
- Protocol errors:
  - go, then go again -> `error`=1, `err_code`=10, result outputs unchanged;
  - then go with `finish`=0 -> `error`=0, `busy`=1;
  - from IDLE, finish -> `err_code`=01.
- Saturation, CNT_WIDTH=3: go plus 9 valid samples, then finish -> `count`=7.
- Reset mid-RUN after 3 samples -> next cycle all outputs 0, state IDLE; a subsequent clean session produces correct results.

Source files
------------

// File: rtl/range_stats_unit.sv
`default_nettype none
// ============================================================================
// Module      : range_stats_unit
// Description : Streaming min/max/range/count tracker for a qualified sample
//               stream over a go..finish session, with signed or unsigned
//               compare, coded protocol errors and a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module range_stats_unit #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16,
  parameter bit SIGNED    = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 valid,
  input  logic                 go,
  input  logic                 finish,
  output logic [WIDTH-1:0]     range,
  output logic [WIDTH-1:0]     min_out,
  output logic [WIDTH-1:0]     max_out,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 done,
  output logic                 busy,
  output logic                 error,
  output logic [1:0]           err_code
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [1:0] c_ERR_NONE   = 2'b00;
  localparam logic [1:0] c_ERR_FINISH = 2'b01;
  localparam logic [1:0] c_ERR_GO     = 2'b10;

  state_t               state_q;
  logic [WIDTH-1:0]     run_min_q, run_max_q;
  logic [CNT_WIDTH-1:0] run_cnt_q;
  logic [WIDTH-1:0]     range_q, min_q, max_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 done_q, busy_q, error_q;
  logic [1:0]           err_code_q;

  logic [WIDTH-1:0]     upd_min_d, upd_max_d;
  logic [CNT_WIDTH-1:0] upd_cnt_d;
  logic [WIDTH-1:0]     fin_min_d, fin_max_d, fin_range_d;
  logic [CNT_WIDTH-1:0] fin_cnt_d;

  // Ordering in the configured interpretation (two's complement or unsigned)
  function automatic logic less_than(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
    if (SIGNED) return $signed(a) < $signed(b);
    else        return a < b;
  endfunction

  // Running statistics as they would be after absorbing the current sample,
  // and the values to publish if the session closes this cycle
  always_comb begin
    upd_min_d   = less_than(data_in, run_min_q) ? data_in : run_min_q;
    upd_max_d   = less_than(run_max_q, data_in) ? data_in : run_max_q;
    upd_cnt_d   = (&run_cnt_q) ? run_cnt_q : run_cnt_q + CNT_WIDTH'(1);
    fin_min_d   = valid ? upd_min_d : run_min_q;
    fin_max_d   = valid ? upd_max_d : run_max_q;
    fin_cnt_d   = valid ? upd_cnt_d : run_cnt_q;
    // max >= min in the chosen interpretation, so the modular difference is exact
    fin_range_d = fin_max_d - fin_min_d;
  end

  // Session FSM with running accumulators and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      run_min_q  <= '0;
      run_max_q  <= '0;
      run_cnt_q  <= '0;
      range_q    <= '0;
      min_q      <= '0;
      max_q      <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= c_ERR_NONE;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_ERROR: begin
          if (go && !finish) begin
            // The go cycle always counts as the first sample
            run_min_q  <= data_in;
            run_max_q  <= data_in;
            run_cnt_q  <= CNT_WIDTH'(1);
            err_code_q <= c_ERR_NONE;
            error_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end else if (finish && (state_q == S_IDLE)) begin
            err_code_q <= c_ERR_FINISH;
            error_q    <= 1'b1;
            state_q    <= S_ERROR;
          end
        end
        S_RUN: begin
          if (go) begin
            // Abandon the session; published results stay as they were
            err_code_q <= c_ERR_GO;
            error_q    <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_ERROR;
          end else if (finish) begin
            min_q   <= fin_min_d;
            max_q   <= fin_max_d;
            range_q <= fin_range_d;
            count_q <= fin_cnt_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else if (valid) begin
            run_min_q <= upd_min_d;
            run_max_q <= upd_max_d;
            run_cnt_q <= upd_cnt_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign range    = range_q;
  assign min_out  = min_q;
  assign max_out  = max_q;
  assign count    = count_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign error    = error_q;
  assign err_code = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_range_stats_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_range_stats_unit
// Description : Scoreboard bench for range_stats_unit; three instances cover
//               unsigned, signed and narrow-counter saturation behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_range_stats_unit;

  typedef struct packed {
    logic [7:0]  mn;
    logic [7:0]  mx;
    logic [7:0]  rg;
    logic [15:0] cnt;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [7:0] din    [3];
  logic       val_s  [3];
  logic       go_s   [3];
  logic       fin_s  [3];

  logic [7:0]  rng0, min0, max0, rng1, min1, max1, rng2, min2, max2;
  logic [15:0] cnt0, cnt1;
  logic [2:0]  cnt2;
  logic        done0, busy0, err0, done1, busy1, err1, done2, busy2, err2;
  logic [1:0]  ec0, ec1, ec2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int tests;
  int fails;

  range_stats_unit #(.WIDTH(8), .CNT_WIDTH(16), .SIGNED(1'b0)) u_uns (
    .clock(clock), .reset(reset), .data_in(din[0]), .valid(val_s[0]),
    .go(go_s[0]), .finish(fin_s[0]), .range(rng0), .min_out(min0),
    .max_out(max0), .count(cnt0), .done(done0), .busy(busy0),
    .error(err0), .err_code(ec0));

  range_stats_unit #(.WIDTH(8), .CNT_WIDTH(16), .SIGNED(1'b1)) u_sgn (
    .clock(clock), .reset(reset), .data_in(din[1]), .valid(val_s[1]),
    .go(go_s[1]), .finish(fin_s[1]), .range(rng1), .min_out(min1),
    .max_out(max1), .count(cnt1), .done(done1), .busy(busy1),
    .error(err1), .err_code(ec1));

  range_stats_unit #(.WIDTH(8), .CNT_WIDTH(3), .SIGNED(1'b0)) u_sat (
    .clock(clock), .reset(reset), .data_in(din[2]), .valid(val_s[2]),
    .go(go_s[2]), .finish(fin_s[2]), .range(rng2), .min_out(min2),
    .max_out(max2), .count(cnt2), .done(done2), .busy(busy2),
    .error(err2), .err_code(ec2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_result(input string tag, input exp_t e,
                            input logic [7:0] mn, input logic [7:0] mx,
                            input logic [7:0] rg, input logic [15:0] cn);
    chk({tag, ".min_out"}, {24'd0, mn}, {24'd0, e.mn});
    chk({tag, ".max_out"}, {24'd0, mx}, {24'd0, e.mx});
    chk({tag, ".range"},   {24'd0, rg}, {24'd0, e.rg});
    chk({tag, ".count"},   {16'd0, cn}, {16'd0, e.cnt});
  endtask

  // One clock cycle of stimulus on instance k; inputs return to zero afterwards
  task automatic step(input int k, input logic g, input logic f, input logic v,
                      input logic [7:0] d);
    go_s[k] = g; fin_s[k] = f; val_s[k] = v; din[k] = d;
    @(posedge clock); #1;
    go_s[k] = 1'b0; fin_s[k] = 1'b0; val_s[k] = 1'b0; din[k] = 8'd0;
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (done0) begin
      if (q0.size() == 0) chk("u_uns.unexpected_done", 32'd1, 32'd0);
      else chk_result("u_uns", q0.pop_front(), min0, max0, rng0, cnt0);
    end
  end

  always @(negedge clock) begin
    if (done1) begin
      if (q1.size() == 0) chk("u_sgn.unexpected_done", 32'd1, 32'd0);
      else chk_result("u_sgn", q1.pop_front(), min1, max1, rng1, cnt1);
    end
  end

  always @(negedge clock) begin
    if (done2) begin
      if (q2.size() == 0) chk("u_sat.unexpected_done", 32'd1, 32'd0);
      else chk_result("u_sat", q2.pop_front(), min2, max2, rng2, {13'd0, cnt2});
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din[k] = 8'd0; val_s[k] = 1'b0; go_s[k] = 1'b0; fin_s[k] = 1'b0;
    end
    repeat (2) @(posedge clock);
    #1;
    chk("reset.range", {24'd0, rng0}, 32'd0);
    chk("reset.min_out", {24'd0, min0}, 32'd0);
    chk("reset.max_out", {24'd0, max0}, 32'd0);
    chk("reset.count", {16'd0, cnt0}, 32'd0);
    chk("reset.flags", {28'd0, done0, busy0, err0, 1'b0}, 32'd0);
    chk("reset.err_code", {30'd0, ec0}, 32'd0);
    reset = 1'b0;
    step(0, 0, 0, 0, 8'd0);

    // Unsigned session with finish carrying a valid sample
    q0.push_back('{mn: 8'd10, mx: 8'd90, rg: 8'd80, cnt: 16'd5});
    step(0, 1, 0, 0, 8'd50);
    chk("t1.busy_after_go", {31'd0, busy0}, 32'd1);
    step(0, 0, 0, 1, 8'd20);
    step(0, 0, 0, 1, 8'd90);
    step(0, 0, 0, 1, 8'd70);
    chk("t1.done_before_finish", {31'd0, done0}, 32'd0);
    step(0, 0, 1, 1, 8'd10);
    chk("t1.done_cycle_after_finish", {31'd0, done0}, 32'd1);
    chk("t1.busy_after_finish", {31'd0, busy0}, 32'd0);
    step(0, 0, 0, 0, 8'd0);
    chk("t1.done_falls", {31'd0, done0}, 32'd0);

    // Signed session: -5, 100, -128, finish without valid
    q1.push_back('{mn: 8'h80, mx: 8'd100, rg: 8'd228, cnt: 16'd3});
    step(1, 1, 0, 0, 8'hFB);
    step(1, 0, 0, 1, 8'd100);
    step(1, 0, 0, 1, 8'h80);
    step(1, 0, 1, 0, 8'd127);
    step(1, 0, 0, 0, 8'd0);

    // Valid gaps: unqualified extremes must not be absorbed
    q0.push_back('{mn: 8'd40, mx: 8'd60, rg: 8'd20, cnt: 16'd2});
    step(0, 1, 0, 0, 8'd40);
    step(0, 0, 0, 0, 8'd0);
    step(0, 0, 0, 0, 8'd255);
    step(0, 0, 0, 0, 8'd0);
    step(0, 0, 0, 1, 8'd60);
    step(0, 0, 1, 0, 8'd0);
    step(0, 0, 0, 0, 8'd0);

    // go during a session: error 10, published results untouched
    step(0, 1, 0, 0, 8'd5);
    step(0, 1, 0, 0, 8'd7);
    chk("t4.error_go", {31'd0, err0}, 32'd1);
    chk("t4.err_code_go", {30'd0, ec0}, 32'd2);
    chk("t4.busy_in_error", {31'd0, busy0}, 32'd0);
    chk("t4.range_held", {24'd0, rng0}, 32'd20);
    chk("t4.count_held", {16'd0, cnt0}, 32'd2);
    // Restart out of ERROR
    q0.push_back('{mn: 8'd9, mx: 8'd9, rg: 8'd0, cnt: 16'd1});
    step(0, 1, 0, 0, 8'd9);
    chk("t4.error_cleared", {31'd0, err0}, 32'd0);
    chk("t4.busy_restart", {31'd0, busy0}, 32'd1);
    chk("t4.err_code_cleared", {30'd0, ec0}, 32'd0);
    step(0, 0, 1, 0, 8'd0);
    step(0, 0, 0, 0, 8'd0);
    // finish from IDLE
    step(0, 0, 1, 0, 8'd0);
    chk("t4.error_finish", {31'd0, err0}, 32'd1);
    chk("t4.err_code_finish", {30'd0, ec0}, 32'd1);
    // go together with finish keeps ERROR
    step(0, 1, 1, 0, 8'd33);
    chk("t4.go_finish_stays_error", {29'd0, err0, ec0}, 32'd5);
    chk("t4.go_finish_not_busy", {31'd0, busy0}, 32'd0);
    q0.push_back('{mn: 8'd3, mx: 8'd200, rg: 8'd197, cnt: 16'd2});
    step(0, 1, 0, 0, 8'd3);
    step(0, 0, 1, 1, 8'd200);
    step(0, 0, 0, 0, 8'd0);

    // Saturation with a 3-bit counter: 10 samples clamp at 7
    q2.push_back('{mn: 8'd1, mx: 8'd10, rg: 8'd9, cnt: 16'd7});
    step(2, 1, 0, 0, 8'd1);
    for (int i = 0; i < 9; i++) step(2, 0, 0, 1, 8'(i + 2));
    step(2, 0, 1, 0, 8'd0);
    step(2, 0, 0, 0, 8'd0);

    // Reset in the middle of a session after three samples
    step(0, 1, 0, 0, 8'd11);
    step(0, 0, 0, 1, 8'd22);
    step(0, 0, 0, 1, 8'd33);
    reset = 1'b1;
    step(0, 0, 0, 0, 8'd0);
    chk("t6.range", {24'd0, rng0}, 32'd0);
    chk("t6.min_out", {24'd0, min0}, 32'd0);
    chk("t6.max_out", {24'd0, max0}, 32'd0);
    chk("t6.count", {16'd0, cnt0}, 32'd0);
    chk("t6.flags", {29'd0, done0, busy0, err0}, 32'd0);
    chk("t6.err_code", {30'd0, ec0}, 32'd0);
    reset = 1'b0;
    q0.push_back('{mn: 8'd30, mx: 8'd90, rg: 8'd60, cnt: 16'd3});
    step(0, 1, 0, 0, 8'd70);
    step(0, 0, 0, 1, 8'd30);
    step(0, 0, 1, 1, 8'd90);
    repeat (3) step(0, 0, 0, 0, 8'd0);

    chk("end.u_uns_pending", q0.size(), 32'd0);
    chk("end.u_sgn_pending", q1.size(), 32'd0);
    chk("end.u_sat_pending", q2.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
